// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
//   SEG_OFF       : active-low segment pattern with every segment dark
//   scan_state_t  : slot phase, blanked or showing a digit
//   nibble_t      : one hex digit
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        StBlank,
        StShow
    } scan_state_t;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern (purely combinational).
//   nibble : in  4  hex digit 0..F
//   seg    : out 7  segments {g,f,e,d,c,b,a}, active-low
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  nibble_t    nibble,
    output logic [6:0] seg
);

    logic [6:0] lit; // active-high {g,f,e,d,c,b,a}

    always_comb begin
        lit = 7'h00;
        unique case (nibble)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            4'hF: lit = 7'h71;
        endcase
    end

    assign seg = ~lit;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for DIGITS seven-segment digits sharing one decoder.
// Each digit slot lasts PRESCALE cycles, the first BLANK of which keep all anodes off.
// A newly loaded value waits in a shadow register and is promoted to the displayed
// (active) register only at a frame boundary, so a frame never mixes two values.
//   clk        : in   system clock, rising edge
//   rst        : in   asynchronous active-high reset
//   value      : in   4*DIGITS  nibble k drives digit k
//   load       : in   capture value into the shadow register
//   enable     : in   0 forces all anodes off; scanning continues
//   an         : out  DIGITS    digit select, active-low
//   seg        : out  7         segments, active-low
//   pending    : out  shadow holds a value not yet shown
//   frame_done : out  pulse on the last cycle of the last digit slot
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  enable,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned DIG_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);

    logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]    digit_q, digit_d;
    scan_state_t         state_q, state_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic                pending_q, pending_d;
    nibble_t             nib_q, nib_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                frame_done_q, frame_done_d;
    logic [6:0]          dec_seg;
    logic                wrap, boundary;

    seven_seg_decoder u_decoder (
        .nibble (nib_q),
        .seg    (dec_seg)
    );

    // All *_d values describe the cycle after the coming edge, so the registered
    // outputs line up with the registered counters.
    always_comb begin
        wrap     = (slot_cnt_q == CNT_LAST);
        boundary = wrap && (digit_q == DIG_LAST);

        slot_cnt_d = wrap ? '0 : slot_cnt_q + CNT_W'(1);
        digit_d    = digit_q;
        if (wrap) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
        end

        state_d = state_q;
        unique case (state_q)
            StBlank: if (slot_cnt_d == CNT_BLANK) state_d = StShow;
            StShow:  if (wrap)                    state_d = StBlank;
        endcase

        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load) begin
            shadow_d = value;
            if (boundary) begin
                // Loaded right on the boundary: skip the shadow stage.
                active_d  = value;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        // Nibble is staged one cycle ahead; since every slot opens with at least one
        // blank cycle, seg already carries the right digit when its anode first drops.
        nib_d = active_d[{digit_d, 2'b00} +: 4];

        an_d  = '1;
        seg_d = SEG_OFF;
        if (state_d == StShow) begin
            seg_d = dec_seg;
            if (enable) begin
                an_d = ~(DIGITS'(1) << digit_d);
            end
        end

        frame_done_d = (slot_cnt_d == CNT_LAST) && (digit_d == DIG_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            digit_q      <= '0;
            state_q      <= StBlank;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            nib_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_q      <= digit_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            nib_q        <= nib_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with DIGITS=2, PRESCALE=8, BLANK=2.
// The driver pushes one record per frame (value expected on display, lit-cycle counts);
// the monitor checks every lit cycle against the front record and pops it on frame_done.
module tb_seven_seg_scan_ctrl;

    typedef struct {
        logic [7:0] val;
        int         n0;
        int         n1;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'h00;
    logic       load = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] an;
    logic [6:0] seg;
    logic       pending;
    logic       frame_done;

    int     cyc;
    int     n_checks = 0;
    int     n_pass = 0;
    int     n_frames = 0;
    int     lit0 = 0;
    int     lit1 = 0;
    logic   mon_on = 1'b0;
    frame_t sb[$];

    // Bench-side model: value on display this frame and a not-yet-shown load.
    logic [7:0] shown = 8'h00;
    logic [7:0] pend_val = 8'h00;
    logic       pend_flag = 1'b0;

    seven_seg_scan_ctrl #(
        .DIGITS   (2),
        .PRESCALE (8),
        .BLANK    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .enable     (enable),
        .an         (an),
        .seg        (seg),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (rst || !mon_on) begin
            lit0 = 0;
            lit1 = 0;
        end else begin
            if (an != 2'b11) begin
                check_eq("an_onehot", 32'(an == 2'b10 || an == 2'b01), 1);
                check_eq("sb_has_frame", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    if (an == 2'b01) begin
                        check_eq("seg_digit1", seg, exp_seg(sb[0].val[7:4]));
                        lit1++;
                    end else begin
                        check_eq("seg_digit0", seg, exp_seg(sb[0].val[3:0]));
                        lit0++;
                    end
                end
            end
            if (frame_done) begin
                check_eq("frame_done_phase", cyc % 16, 15);
                check_eq("sb_pop_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check_eq("lit_count_d0", lit0, sb[0].n0);
                    check_eq("lit_count_d1", lit1, sb[0].n1);
                    void'(sb.pop_front());
                end
                n_frames++;
                lit0 = 0;
                lit1 = 0;
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic new_frame(input int f, input int n0, input int n1);
        frame_t fr;
        goto(16 * f);
        if (pend_flag) shown = pend_val;
        pend_flag = 1'b0;
        fr.val = shown;
        fr.n0  = n0;
        fr.n1  = n1;
        sb.push_back(fr);
    endtask

    // Assert load during cycle c; returns at cycle c+1.
    task automatic do_load(input int c, input logic [7:0] v);
        goto(c);
        value     = v;
        load      = 1'b1;
        pend_val  = v;
        pend_flag = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        value = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;

        // Reset state and first slot.
        new_frame(0, 6, 6);
        check_eq("rst_an", an, 2'b11);
        check_eq("rst_seg", seg, 7'h7F);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_frame_done", frame_done, 0);
        goto(1);
        check_eq("blank1_an", an, 2'b11);
        check_eq("blank1_seg", seg, 7'h7F);
        goto(2);
        check_eq("first_show_an", an, 2'b10);
        check_eq("first_show_seg", seg, 7'h40);

        // Load at frame start: held in shadow until the boundary.
        new_frame(1, 6, 6);
        do_load(16, 8'h3A);
        check_eq("pending_after_load", pending, 1);
        goto(31);
        check_eq("pending_held", pending, 1);
        check_eq("frame_done_31", frame_done, 1);

        // Two loads in one frame: only the second is ever shown.
        new_frame(2, 6, 6);
        check_eq("pending_cleared", pending, 0);
        do_load(36, 8'h12);
        do_load(40, 8'h34);

        // Load on the boundary cycle goes straight to the display.
        new_frame(3, 6, 6);
        do_load(63, 8'h56);
        check_eq("pending_boundary_load", pending, 0);

        new_frame(4, 6, 6);
        goto(79);
        enable = 1'b0;

        // Whole frame dark, frame_done still pulses.
        new_frame(5, 0, 0);

        // Enable rises mid-SHOW of digit 0: lights next cycle, slot not restarted.
        new_frame(6, 4, 6);
        goto(99);
        check_eq("en_low_an", an, 2'b11);
        enable = 1'b1;
        goto(100);
        check_eq("en_rise_an", an, 2'b10);

        // Reset mid-SHOW of digit 1 with a pending value.
        new_frame(7, 6, 6);
        do_load(113, 8'h9E);
        check_eq("pending_before_rst", pending, 1);
        goto(124);
        check_eq("digit1_lit", an, 2'b01);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_an", an, 2'b11);
        check_eq("async_rst_seg", seg, 7'h7F);
        check_eq("async_rst_pending", pending, 0);
        sb.delete();
        pend_flag = 1'b0;
        shown     = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Discarded value must never appear.
        new_frame(0, 6, 6);
        new_frame(1, 6, 6);
        goto(32);

        check_eq("sb_drained", sb.size(), 0);
        check_eq("frames_seen", n_frames, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
